// File: rtl/str_to_num.sv
// ---------------------------------------------------------------------------
// str_to_num
//
// Scans an ASCII byte stream and emits every unsigned number found in it as a
// W-bit word. Decimal tokens are runs of '0'..'9'. Hex tokens are "0x"/"0X"
// followed by hex digits. Any other byte terminates the current token. The
// terminating byte is consumed and never starts a new token.
//
// Optional feature macro: STR_TO_NUM_HEX_EN
//   defined   : hex tokens are recognised (ZERO/HPFX/HEX states exist)
//   undefined : decimal only; '0' is an ordinary digit, 'x'/'X' terminate,
//               m_hex is tied to 0
//
// Parameters
//   W      width of the accumulator and of m_dtm (>= 8)
//
// Ports
//   clk    in   clock, all logic on posedge
//   rst_n  in   synchronous active-low reset
//   s_dtm  in   [7:0] input ASCII byte
//   s_vld  in   input byte valid
//   s_rdy  out  input byte accepted when s_vld && s_rdy
//   m_dtm  out  [W-1:0] parsed value
//   m_hex  out  value came from a hex token
//   m_ovf  out  value overflowed W bits during accumulation (wrapped)
//   m_vld  out  output valid
//   m_rdy  in   output taken when m_vld && m_rdy
// ---------------------------------------------------------------------------
module str_to_num #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   s_dtm,
    input  logic         s_vld,
    output logic         s_rdy,
    output logic [W-1:0] m_dtm,
    output logic         m_hex,
    output logic         m_ovf,
    output logic         m_vld,
    input  logic         m_rdy
);

`ifdef STR_TO_NUM_HEX_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEC  = 3'd1,
        ZERO = 3'd2,
        HPFX = 3'd3,
        HEX  = 3'd4
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DEC  = 1'b1
    } state_t;
`endif

    // One decimal accumulation step, returned W+4 bits wide so that the
    // bits above W flag an overflow of the true (unwrapped) result.
    function automatic logic [W+3:0] dec_step(input logic [W-1:0] a,
                                              input logic [3:0]   d);
        return ({4'b0000, a} * (W+4)'(10)) + {{W{1'b0}}, d};
    endfunction

`ifdef STR_TO_NUM_HEX_EN
    // Hex digit value; only meaningful when the byte is a hex digit.
    // Letters 'a'..'f' / 'A'..'F' have low nibbles 1..6, hence the +9.
    function automatic logic [3:0] hex_val(input logic [7:0] b);
        if (b <= 8'h39) begin
            return b[3:0];
        end
        return b[3:0] + 4'd9;
    endfunction

    // One hex accumulation step; the top nibble shifted out flags overflow.
    function automatic logic [W+3:0] hex_step(input logic [W-1:0] a,
                                              input logic [3:0]   h);
        return {a, h};
    endfunction
`endif

    state_t         state, state_n;
    logic [W-1:0]   acc, acc_n;
    logic           ovf, ovf_n;

    logic           accept;
    logic           is_dig;
    logic [3:0]     dig_val;
    logic [W+3:0]   dec_wide;
    logic           dec_carry;

    logic           emit;
    logic [W-1:0]   emit_val;
    logic           emit_ovf;

    logic [W-1:0]   dtm_p1;
    logic           ovf_p1;
    logic           vld_p1;

`ifdef STR_TO_NUM_HEX_EN
    logic           is_hx;
    logic           is_x;
    logic [3:0]     hx_val;
    logic [W+3:0]   hex_wide;
    logic           hex_carry;
    logic           emit_hex;
    logic           hex_p1;
`endif

    // Input is accepted whenever the output slot is empty or draining this
    // cycle, so a drained output never costs a bubble.
    assign s_rdy  = rst_n && (!vld_p1 || m_rdy);
    assign accept = s_vld && s_rdy;

    assign is_dig    = (s_dtm >= 8'h30) && (s_dtm <= 8'h39);
    assign dig_val   = s_dtm[3:0];
    assign dec_wide  = dec_step(acc, dig_val);
    assign dec_carry = |dec_wide[W+3:W];

`ifdef STR_TO_NUM_HEX_EN
    assign is_hx     = is_dig
                    || ((s_dtm >= 8'h61) && (s_dtm <= 8'h66))
                    || ((s_dtm >= 8'h41) && (s_dtm <= 8'h46));
    assign is_x      = (s_dtm == 8'h78) || (s_dtm == 8'h58);
    assign hx_val    = hex_val(s_dtm);
    assign hex_wide  = hex_step(acc, hx_val);
    assign hex_carry = |hex_wide[W+3:W];
`endif

    // ---- stage p0: token recognition and accumulation ----
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        ovf_n    = ovf;
        emit     = 1'b0;
        emit_val = '0;
        emit_ovf = 1'b0;
`ifdef STR_TO_NUM_HEX_EN
        emit_hex = 1'b0;
`endif
        if (accept) begin
            case (state)
                IDLE: begin
                    if (is_dig) begin
`ifdef STR_TO_NUM_HEX_EN
                        // A leading '0' may be the start of a "0x" prefix.
                        state_n = (dig_val == 4'd0) ? ZERO : DEC;
`else
                        state_n = DEC;
`endif
                        acc_n = {{(W-4){1'b0}}, dig_val};
                        ovf_n = 1'b0;
                    end
                end
                DEC: begin
                    if (is_dig) begin
                        acc_n = dec_wide[W-1:0];
                        ovf_n = ovf | dec_carry;
                    end else begin
                        emit     = 1'b1;
                        emit_val = acc;
                        emit_ovf = ovf;
                        state_n  = IDLE;
                        acc_n    = '0;
                        ovf_n    = 1'b0;
                    end
                end
`ifdef STR_TO_NUM_HEX_EN
                ZERO: begin
                    if (is_x) begin
                        state_n = HPFX;
                    end else if (is_dig) begin
                        state_n = DEC;
                        acc_n   = {{(W-4){1'b0}}, dig_val};
                        ovf_n   = 1'b0;
                    end else begin
                        emit    = 1'b1;
                        state_n = IDLE;
                        acc_n   = '0;
                        ovf_n   = 1'b0;
                    end
                end
                HPFX: begin
                    if (is_hx) begin
                        state_n = HEX;
                        acc_n   = {{(W-4){1'b0}}, hx_val};
                        ovf_n   = 1'b0;
                    end else begin
                        // A bare "0x" still yields a hex zero.
                        emit     = 1'b1;
                        emit_hex = 1'b1;
                        state_n  = IDLE;
                        acc_n    = '0;
                        ovf_n    = 1'b0;
                    end
                end
                HEX: begin
                    if (is_hx) begin
                        acc_n = hex_wide[W-1:0];
                        ovf_n = ovf | hex_carry;
                    end else begin
                        emit     = 1'b1;
                        emit_val = acc;
                        emit_hex = 1'b1;
                        emit_ovf = ovf;
                        state_n  = IDLE;
                        acc_n    = '0;
                        ovf_n    = 1'b0;
                    end
                end
`endif
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            ovf   <= ovf_n;
        end
    end

    // ---- stage p1: output register, held while stalled ----
    // An emit can only occur when the slot is free or draining (s_rdy), so
    // loading it never overwrites an untaken result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            dtm_p1 <= '0;
            ovf_p1 <= 1'b0;
        end else if (emit) begin
            vld_p1 <= 1'b1;
            dtm_p1 <= emit_val;
            ovf_p1 <= emit_ovf;
        end else if (m_rdy) begin
            vld_p1 <= 1'b0;
        end
    end

`ifdef STR_TO_NUM_HEX_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex_p1 <= 1'b0;
        end else if (emit) begin
            hex_p1 <= emit_hex;
        end
    end
    assign m_hex = hex_p1;
`else
    assign m_hex = 1'b0;
`endif

    assign m_dtm = dtm_p1;
    assign m_ovf = ovf_p1;
    assign m_vld = vld_p1;

endmodule
